// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RISC-V core: ALU-control classes,
// writeback-select encodings and default datapath widths.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef enum logic [2:0] {
    EX_ADD  = 3'd0,
    EX_SUB  = 3'd1,
    EX_AND  = 3'd2,
    EX_OR   = 3'd3,
    EX_ADDI = 3'd4,
    EX_SLTI = 3'd5,
    EX_ORI  = 3'd6,
    EX_XORI = 3'd7
  } ex_code_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reused for performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and a saturating
// count of inserted bubbles.
module id_ex_reg
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [2:0]       id_ex_code,
  input  logic             id_reg_write,
  input  logic             id_mem_write,
  input  logic             id_jump,
  input  logic             id_branch,
  input  logic             id_alu_src,
  input  logic [1:0]       id_result_src,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [2:0]       ex_ex_code,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_jump,
  output logic             ex_branch,
  output logic             ex_alu_src,
  output logic [1:0]       ex_result_src,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic bubble_inc;

  // A bubble is either forced by flush or loaded as an invalid slot; stalls never count.
  assign bubble_inc = flush | (~stall & ~id_valid);

  // Data fields are cleared on a bubble too, so forwarding cannot match a stale rs address.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_ex_code    <= EX_ADD;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_jump       <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_result_src <= RES_ALU;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_rd1        <= id_rd1;
      ex_rd2        <= id_rd2;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_ex_code    <= id_ex_code;
      ex_reg_write  <= id_reg_write;
      ex_mem_write  <= id_mem_write;
      ex_jump       <= id_jump;
      ex_branch     <= id_branch;
      ex_alu_src    <= id_alu_src;
      ex_result_src <= id_result_src;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, hand sequences for saturation and
// reset-during-stall, then randomized traffic against a behavioural model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  code;
    logic        rw;
    logic        mw;
    logic        j;
    logic        b;
    logic        as;
    logic [1:0]  rs;
  } fields_t;

  typedef struct {
    bit      rst;
    bit      stall;
    bit      flush;
    fields_t in;
    fields_t exp;
    int      exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush;
  fields_t din;

  logic        ex_valid, ex_reg_write, ex_mem_write, ex_jump, ex_branch, ex_alu_src;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_ex_code;
  logic [1:0]  ex_result_src;
  logic [15:0] bubble_cnt;

  logic        v4, rw4, mw4, j4, b4, as4;
  logic [31:0] pc4, rd14, rd24, imm4;
  logic [4:0]  rs14, rs24, rd4;
  logic [2:0]  code4;
  logic [1:0]  rsrc4;
  logic [3:0]  bubble_cnt4;

  id_ex_reg #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(din.valid), .id_pc(din.pc), .id_rd1(din.rd1), .id_rd2(din.rd2),
    .id_imm(din.imm), .id_rs1(din.rs1), .id_rs2(din.rs2), .id_rd(din.rd),
    .id_ex_code(din.code), .id_reg_write(din.rw), .id_mem_write(din.mw),
    .id_jump(din.j), .id_branch(din.b), .id_alu_src(din.as), .id_result_src(din.rs),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ex_code(ex_ex_code), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_result_src(ex_result_src), .bubble_cnt(bubble_cnt)
  );

  id_ex_reg #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(din.valid), .id_pc(din.pc), .id_rd1(din.rd1), .id_rd2(din.rd2),
    .id_imm(din.imm), .id_rs1(din.rs1), .id_rs2(din.rs2), .id_rd(din.rd),
    .id_ex_code(din.code), .id_reg_write(din.rw), .id_mem_write(din.mw),
    .id_jump(din.j), .id_branch(din.b), .id_alu_src(din.as), .id_result_src(din.rs),
    .ex_valid(v4), .ex_pc(pc4), .ex_rd1(rd14), .ex_rd2(rd24),
    .ex_imm(imm4), .ex_rs1(rs14), .ex_rs2(rs24), .ex_rd(rd4),
    .ex_ex_code(code4), .ex_reg_write(rw4), .ex_mem_write(mw4),
    .ex_jump(j4), .ex_branch(b4), .ex_alu_src(as4),
    .ex_result_src(rsrc4), .bubble_cnt(bubble_cnt4)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: architectural contents of EX plus an unbounded bubble tally.
  fields_t m_ex;
  int      m_bubbles;

  function automatic fields_t mk(bit v, logic [31:0] pc, logic [31:0] rd1,
                                 logic [4:0] rd, logic [2:0] code, bit rw);
    fields_t f;
    f.valid = v;
    f.pc    = pc;
    f.rd1   = rd1;
    f.rd2   = pc ^ 32'hA5A5_5A5A;
    f.imm   = pc + 32'd4;
    f.rs1   = rd ^ 5'd3;
    f.rs2   = rd + 5'd1;
    f.rd    = rd;
    f.code  = code;
    f.rw    = rw;
    f.mw    = code[1];
    f.j     = code[0];
    f.b     = code[2];
    f.as    = ~code[0];
    f.rs    = code[1:0];
    return f;
  endfunction

  function automatic fields_t rnd_fields();
    fields_t f;
    f.valid = ($urandom_range(0, 9) < 8);
    f.pc    = $urandom;
    f.rd1   = $urandom;
    f.rd2   = $urandom;
    f.imm   = $urandom;
    f.rs1   = 5'($urandom);
    f.rs2   = 5'($urandom);
    f.rd    = 5'($urandom);
    f.code  = 3'($urandom);
    f.rw    = 1'($urandom);
    f.mw    = 1'($urandom);
    f.j     = 1'($urandom);
    f.b     = 1'($urandom);
    f.as    = 1'($urandom);
    f.rs    = 2'($urandom_range(0, 2));
    return f;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic fields_t dut_fields();
    fields_t f;
    f = '{ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ex_code,
          ex_reg_write, ex_mem_write, ex_jump, ex_branch, ex_alu_src, ex_result_src};
    return f;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_fields(string tag, fields_t a, fields_t e);
    chk({tag, ".valid"}, 64'(a.valid), 64'(e.valid));
    chk({tag, ".pc"},    64'(a.pc),    64'(e.pc));
    chk({tag, ".rd1"},   64'(a.rd1),   64'(e.rd1));
    chk({tag, ".rd2"},   64'(a.rd2),   64'(e.rd2));
    chk({tag, ".imm"},   64'(a.imm),   64'(e.imm));
    chk({tag, ".rs1"},   64'(a.rs1),   64'(e.rs1));
    chk({tag, ".rs2"},   64'(a.rs2),   64'(e.rs2));
    chk({tag, ".rd"},    64'(a.rd),    64'(e.rd));
    chk({tag, ".ex_code"}, 64'(a.code), 64'(e.code));
    chk({tag, ".reg_write"}, 64'(a.rw), 64'(e.rw));
    chk({tag, ".mem_write"}, 64'(a.mw), 64'(e.mw));
    chk({tag, ".jump"},   64'(a.j),  64'(e.j));
    chk({tag, ".branch"}, 64'(a.b),  64'(e.b));
    chk({tag, ".alu_src"}, 64'(a.as), 64'(e.as));
    chk({tag, ".result_src"}, 64'(a.rs), 64'(e.rs));
  endtask

  task automatic cmp_model(string tag);
    cmp_fields(tag, dut_fields(), m_ex);
    chk({tag, ".bubble_cnt"},  64'(bubble_cnt),  64'(sat(m_bubbles, 65535)));
    chk({tag, ".bubble_cnt4"}, 64'(bubble_cnt4), 64'(sat(m_bubbles, 15)));
  endtask

  // Drive one cycle, advance the model by the stated rules, sample 1 time unit after the edge.
  task automatic apply(bit r, bit s, bit f, fields_t in);
    rst = r; stall = s; flush = f; din = in;
    @(posedge clk);
    if (r) begin
      m_ex = '0;
      m_bubbles = 0;
    end else if (f) begin
      m_ex = '0;
      m_bubbles++;
    end else if (!s) begin
      m_ex = in;
      if (!in.valid) m_bubbles++;
    end
    #1;
  endtask

  vec_t vecs[$];
  fields_t nz, a, b, c, d, e;

  initial begin
    m_ex = '0;
    m_bubbles = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; din = '0;

    nz = mk(1'b1, 32'hFFFF_FFF0, 32'h1111_2222, 5'd31, 3'd6, 1'b1);
    a  = mk(1'b1, 32'h100, 32'hDEAD_BEEF, 5'd2, 3'd5, 1'b0);
    b  = mk(1'b1, 32'h200, 32'h1234_5678, 5'd7, 3'd7, 1'b1);
    c  = mk(1'b1, 32'h300, 32'h0000_0033, 5'd9, 3'd3, 1'b1);
    d  = mk(1'b1, 32'h400, 32'h0000_0044, 5'd4, 3'd1, 1'b1);
    e  = mk(1'b0, 32'h500, 32'h0000_0055, 5'd5, 3'd2, 1'b1);

    vecs.push_back('{1, 0, 0, nz, '0, 0});  // reset cycle 1
    vecs.push_back('{1, 1, 1, nz, '0, 0});  // reset overrides stall/flush
    vecs.push_back('{0, 0, 0, a,  a,  0});  // first load: pc 0x100, code 5
    vecs.push_back('{0, 1, 0, b,  a,  0});  // stall x3 holds DEADBEEF
    vecs.push_back('{0, 1, 0, b,  a,  0});
    vecs.push_back('{0, 1, 0, b,  a,  0});
    vecs.push_back('{0, 0, 0, b,  b,  0});  // release: 12345678, rd=7, code=7
    vecs.push_back('{0, 0, 1, c,  '0, 1});  // flush -> bubble
    vecs.push_back('{0, 0, 0, c,  c,  1});
    vecs.push_back('{0, 1, 1, d,  '0, 2});  // stall+flush -> bubble
    vecs.push_back('{0, 1, 0, d,  '0, 2});  // stall holds bubble, no count
    vecs.push_back('{0, 0, 0, e,  e,  3});  // invalid load: fields loaded, counted

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].in);
      cmp_fields($sformatf("vec%0d", i), dut_fields(), vecs[i].exp);
      chk($sformatf("vec%0d.bubble_cnt", i), 64'(bubble_cnt), 64'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.bubble_cnt4", i), 64'(bubble_cnt4), 64'(vecs[i].exp_cnt));
    end

    // Saturation: 20 back-to-back flushes from reset.
    apply(1'b1, 1'b0, 1'b0, nz);
    for (int i = 1; i <= 20; i++) begin
      apply(1'b0, 1'b0, 1'b1, nz);
      chk($sformatf("sat%0d.bubble_cnt4", i), 64'(bubble_cnt4), 64'(sat(i, 15)));
      chk($sformatf("sat%0d.bubble_cnt", i), 64'(bubble_cnt), 64'(i));
    end

    // Reset during a stall clears everything and releases the hold.
    apply(1'b0, 1'b0, 1'b0, b);
    apply(1'b0, 1'b1, 1'b0, c);
    apply(1'b1, 1'b1, 1'b0, c);
    cmp_fields("rst_in_stall", dut_fields(), '0);
    chk("rst_in_stall.bubble_cnt", 64'(bubble_cnt), 64'd0);
    apply(1'b0, 1'b0, 1'b0, d);
    cmp_fields("after_rst_load", dut_fields(), d);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r, s, f;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 15);
      s = ($urandom_range(0, 99) < 25);
      apply(r, s, f, rnd_fields());
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
